// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the MEM-stage load/store sequencer: operation codes,
// sequencer state encoding, transfer-size codes and op-class helpers.
package lsu_ctrl_pkg;

  // Memory operation codes; bit 3 distinguishes stores from loads.
  typedef enum logic [3:0] {
    LSU_LB  = 4'd0,
    LSU_LBU = 4'd1,
    LSU_LH  = 4'd2,
    LSU_LHU = 4'd3,
    LSU_LW  = 4'd4,
    LSU_LWL = 4'd5,
    LSU_LWR = 4'd6,
    LSU_SB  = 4'd8,
    LSU_SH  = 4'd9,
    LSU_SW  = 4'd10,
    LSU_SWL = 4'd11,
    LSU_SWR = 4'd12
  } lsu_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // Data-port transfer sizes.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // True for the twelve defined memory operations.
  function automatic logic op_is_known(input logic [3:0] op);
    case (op)
      LSU_LB, LSU_LBU, LSU_LH, LSU_LHU, LSU_LW, LSU_LWL, LSU_LWR,
      LSU_SB, LSU_SH, LSU_SW, LSU_SWL, LSU_SWR: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  // True for defined load operations.
  function automatic logic op_is_load(input logic [3:0] op);
    return op_is_known(op) && !op[3];
  endfunction

endpackage

// File: rtl/lsu_ctrl_merge.sv
// Unaligned-word merge for LWL/LWR: combines the returned memory word with
// the current register word according to the byte offset.
module lsu_ctrl_merge
(
  input  logic        left,
  input  logic [31:0] mem_word,
  input  logic [31:0] reg_word,
  input  logic [1:0]  byte_addr,
  output logic [31:0] merged
);

  logic [4:0] left_sh_s;
  logic [4:0] right_sh_s;

  assign left_sh_s  = {2'd3 - byte_addr, 3'b000};
  assign right_sh_s = {byte_addr, 3'b000};

  // LWL places low memory bytes into the top of the register; LWR places
  // high memory bytes into the bottom. Untouched register bytes are kept.
  always_comb begin
    if (left) begin
      merged = (mem_word << left_sh_s) | (reg_word & (32'h00FF_FFFF >> right_sh_s));
    end else begin
      merged = (mem_word >> right_sh_s) | (reg_word & ~(32'hFFFF_FFFF >> right_sh_s));
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store sequencer: issues one SRAM-like data-port transaction
// per memory instruction, stalls the pipeline while it is outstanding,
// formats load data for writeback and drains transactions killed by a flush.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic [3:0]        mem_op,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       rt_value,
  input  logic              flush,
  input  logic              pipe_advance,
  output logic              stall,
  output logic              adel,
  output logic              ades,
  output logic              result_valid,
  output logic [31:0]       result,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata
);

  lsu_state_e        state_q, state_d;
  logic              cancel_q, cancel_d;
  logic [3:0]        op_q, op_d;
  logic [1:0]        b_q, b_d;
  logic [31:0]       rt_q, rt_d;
  logic              data_req_q, data_req_d;
  logic              data_wr_q, data_wr_d;
  logic [1:0]        data_size_q, data_size_d;
  logic [ADDR_W-1:0] data_addr_q, data_addr_d;
  logic [3:0]        data_wstrb_q, data_wstrb_d;
  logic [31:0]       data_wdata_q, data_wdata_d;
  logic [31:0]       result_q, result_d;
  logic              result_valid_q, result_valid_d;

  logic              adel_rule_s, ades_rule_s, accept_s;
  logic [1:0]        req_size_s;
  logic [ADDR_W-1:0] req_addr_s;
  logic [3:0]        req_wstrb_s;
  logic [31:0]       req_wdata_s;
  logic [4:0]        st_sh_s, swl_sh_s;
  logic [7:0]        ld_byte_s;
  logic [15:0]       ld_half_s;
  logic [31:0]       ld_data_s;
  logic [31:0]       merge_left_s, merge_right_s;

  assign st_sh_s  = {mem_addr[1:0], 3'b000};
  assign swl_sh_s = {2'd3 - mem_addr[1:0], 3'b000};

  // Misalignment rules and the IDLE accept condition; an error or a flush
  // keeps the instruction from being issued. Undefined op codes are ignored.
  always_comb begin
    adel_rule_s = 1'b0;
    ades_rule_s = 1'b0;
    case (mem_op)
      LSU_LH, LSU_LHU: adel_rule_s = mem_addr[0];
      LSU_LW:          adel_rule_s = (mem_addr[1:0] != 2'd0);
      LSU_SH:          ades_rule_s = mem_addr[0];
      LSU_SW:          ades_rule_s = (mem_addr[1:0] != 2'd0);
      default: begin
        adel_rule_s = 1'b0;
        ades_rule_s = 1'b0;
      end
    endcase
    accept_s = (state_q == ST_IDLE) && mem_valid && op_is_known(mem_op) &&
               !flush && !adel_rule_s && !ades_rule_s;
  end

  // Exceptions only mean something for a valid instruction waiting in IDLE.
  assign adel  = !reset && (state_q == ST_IDLE) && mem_valid && adel_rule_s;
  assign ades  = !reset && (state_q == ST_IDLE) && mem_valid && ades_rule_s;
  assign stall = !reset && (accept_s || (state_q == ST_REQ) || (state_q == ST_WAIT));

  // Request fields for the incoming instruction: size, address, strobes, data.
  always_comb begin
    req_size_s  = SIZE_WORD;
    req_addr_s  = mem_addr;
    req_wstrb_s = 4'b0000;
    req_wdata_s = 32'h0000_0000;
    case (mem_op)
      LSU_LB, LSU_LBU: req_size_s = SIZE_BYTE;
      LSU_LH, LSU_LHU: req_size_s = SIZE_HALF;
      LSU_LWL, LSU_LWR: req_addr_s = {mem_addr[ADDR_W-1:2], 2'b00};
      LSU_SB: begin
        req_size_s  = SIZE_BYTE;
        req_wstrb_s = 4'b0001 << mem_addr[1:0];
        req_wdata_s = {4{rt_value[7:0]}};
      end
      LSU_SH: begin
        req_size_s  = SIZE_HALF;
        req_wstrb_s = 4'b0011 << mem_addr[1:0];
        req_wdata_s = {2{rt_value[15:0]}};
      end
      LSU_SW: begin
        req_wstrb_s = 4'b1111;
        req_wdata_s = rt_value;
      end
      LSU_SWL: begin
        req_addr_s  = {mem_addr[ADDR_W-1:2], 2'b00};
        req_wstrb_s = (4'b0010 << mem_addr[1:0]) - 4'b0001;
        req_wdata_s = rt_value >> swl_sh_s;
      end
      LSU_SWR: begin
        req_addr_s  = {mem_addr[ADDR_W-1:2], 2'b00};
        req_wstrb_s = 4'b1111 << mem_addr[1:0];
        req_wdata_s = rt_value << st_sh_s;
      end
      default: req_size_s = SIZE_WORD;
    endcase
  end

  lsu_ctrl_merge u_merge_left (
    .left      (1'b1),
    .mem_word  (data_rdata),
    .reg_word  (rt_q),
    .byte_addr (b_q),
    .merged    (merge_left_s)
  );

  lsu_ctrl_merge u_merge_right (
    .left      (1'b0),
    .mem_word  (data_rdata),
    .reg_word  (rt_q),
    .byte_addr (b_q),
    .merged    (merge_right_s)
  );

  // Writeback formatting of returning load data at the latched byte offset.
  always_comb begin
    case (b_q)
      2'd0:    ld_byte_s = data_rdata[7:0];
      2'd1:    ld_byte_s = data_rdata[15:8];
      2'd2:    ld_byte_s = data_rdata[23:16];
      2'd3:    ld_byte_s = data_rdata[31:24];
      default: ld_byte_s = data_rdata[7:0];
    endcase
    if (b_q[1]) begin
      ld_half_s = data_rdata[31:16];
    end else begin
      ld_half_s = data_rdata[15:0];
    end
    case (op_q)
      LSU_LB:  ld_data_s = {{24{ld_byte_s[7]}}, ld_byte_s};
      LSU_LBU: ld_data_s = {24'h00_0000, ld_byte_s};
      LSU_LH:  ld_data_s = {{16{ld_half_s[15]}}, ld_half_s};
      LSU_LHU: ld_data_s = {16'h0000, ld_half_s};
      LSU_LWL: ld_data_s = merge_left_s;
      LSU_LWR: ld_data_s = merge_right_s;
      default: ld_data_s = data_rdata;
    endcase
  end

  // Sequencer next state: issue, hold request until accepted, wait for data,
  // present the result; a flush turns an in-flight transaction into a drain.
  always_comb begin
    state_d        = state_q;
    cancel_d       = cancel_q;
    op_d           = op_q;
    b_d            = b_q;
    rt_d           = rt_q;
    data_req_d     = data_req_q;
    data_wr_d      = data_wr_q;
    data_size_d    = data_size_q;
    data_addr_d    = data_addr_q;
    data_wstrb_d   = data_wstrb_q;
    data_wdata_d   = data_wdata_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d      = ST_REQ;
          cancel_d     = 1'b0;
          op_d         = mem_op;
          b_d          = mem_addr[1:0];
          rt_d         = rt_value;
          data_req_d   = 1'b1;
          data_wr_d    = mem_op[3];
          data_size_d  = req_size_s;
          data_addr_d  = req_addr_s;
          data_wstrb_d = req_wstrb_s;
          data_wdata_d = req_wdata_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (flush) begin
          cancel_d = 1'b1;
        end else begin
          cancel_d = cancel_q;
        end
        if (data_addr_ok) begin
          state_d    = ST_WAIT;
          data_req_d = 1'b0;
        end else begin
          data_req_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (data_data_ok) begin
          cancel_d = 1'b0;
          if (cancel_q || flush) begin
            state_d = ST_IDLE;
          end else begin
            state_d        = ST_DONE;
            result_valid_d = op_is_load(op_q);
            if (op_is_load(op_q)) begin
              result_d = ld_data_s;
            end else begin
              result_d = result_q;
            end
          end
        end else if (flush) begin
          cancel_d = 1'b1;
        end else begin
          cancel_d = cancel_q;
        end
      end
      ST_DONE: begin
        if (flush || pipe_advance) begin
          state_d        = ST_IDLE;
          result_valid_d = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d        = ST_IDLE;
        cancel_d       = 1'b0;
        data_req_d     = 1'b0;
        result_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cancel_q       <= 1'b0;
      op_q           <= 4'd0;
      b_q            <= 2'd0;
      rt_q           <= 32'h0000_0000;
      data_req_q     <= 1'b0;
      data_wr_q      <= 1'b0;
      data_size_q    <= 2'd0;
      data_addr_q    <= {ADDR_W{1'b0}};
      data_wstrb_q   <= 4'b0000;
      data_wdata_q   <= 32'h0000_0000;
      result_q       <= 32'h0000_0000;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cancel_q       <= cancel_d;
      op_q           <= op_d;
      b_q            <= b_d;
      rt_q           <= rt_d;
      data_req_q     <= data_req_d;
      data_wr_q      <= data_wr_d;
      data_size_q    <= data_size_d;
      data_addr_q    <= data_addr_d;
      data_wstrb_q   <= data_wstrb_d;
      data_wdata_q   <= data_wdata_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign data_req     = data_req_q;
  assign data_wr      = data_wr_q;
  assign data_size    = data_size_q;
  assign data_addr    = data_addr_q;
  assign data_wstrb   = data_wstrb_q;
  assign data_wdata   = data_wdata_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule
